// File: rtl/oled_text_feeder.sv
// rtl/oled_text_feeder.sv - 64-cell ASCII text buffer streamed one glyph per send_done edge to the OLED controller
// Optional feature: OLED_FEEDER_AUTO_REFRESH_EN (continuous back-to-back frames after the first refresh).
module oled_text_feeder #(
  parameter int          NUM_CHARS  = 64,
  parameter int          ADDR_W     = 6,
  parameter logic [6:0]  BLANK_CHAR = 7'h20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_char,
  input  logic              clear,
  input  logic              refresh,
  output logic              busy,
  output logic              frame_done,
  output logic [6:0]        send_data,
  output logic              send_data_valid,
  input  logic              send_done
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CHARS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              send_done_q;
  logic              ack;
  logic [6:0]        cells [NUM_CHARS];

  // The controller holds send_done high for many cycles; only its rising edge retires a glyph.
  assign ack = send_done & ~send_done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      send_done_q <= 1'b0;
    end else begin
      send_done_q <= send_done;
    end
  end

  // Clear blanks everything first; a same-cycle write then lands on top of the blank grid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++) cells[i] <= BLANK_CHAR;
    end else begin
      if (clear) begin
        for (int i = 0; i < NUM_CHARS; i++) cells[i] <= BLANK_CHAR;
      end
      if (wr_en) begin
        cells[wr_addr] <= wr_char;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      send_data       <= 7'h00;
      send_data_valid <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (refresh) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          send_data       <= cells[idx];
          send_data_valid <= 1'b1;
          state           <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Valid stays high across cells so the controller's extra page-change read is harmless.
          if (ack) begin
            if (idx == LAST_IDX) begin
              state <= FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
          end
        end
        FINISH: begin
          send_data_valid <= 1'b0;
          frame_done      <= 1'b1;
`ifdef OLED_FEEDER_AUTO_REFRESH_EN
          idx   <= '0;
          state <= LOAD;
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_text_feeder.sv
// tb/tb_oled_text_feeder.sv - directed self-checking bench for oled_text_feeder with a modelled OLED controller
module tb_oled_text_feeder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [6:0] wr_char = '0;
  logic       clear = 1'b0;
  logic       refresh = 1'b0;
  logic       send_done = 1'b0;
  logic       busy, frame_done, send_data_valid;
  logic [6:0] send_data;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [6:0] exp_buf [64];

  typedef struct {
    logic [5:0] addr;
    logic [6:0] ch;
    logic [6:0] exp;
  } wr_vec_t;

  wr_vec_t vecs [6];

  oled_text_feeder dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .clear(clear), .refresh(refresh), .busy(busy), .frame_done(frame_done),
    .send_data(send_data), .send_data_valid(send_data_valid), .send_done(send_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_done) fd_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic write_cell(input logic [5:0] a, input logic [6:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // mode: 0 plain, 1 writes during cell 10, 2 refresh during cell 5, 3 reset at cell 30
  task automatic run_frame(input int hold, input bit do_refresh, input int mode,
                           input bit clr, input bit wr, input logic [5:0] a, input logic [6:0] c);
    int fd0;
    int cnt;
    fd0 = fd_cnt;
    if (do_refresh) begin
      refresh = 1'b1; clear = clr; wr_en = wr; wr_addr = a; wr_char = c;
      @(negedge clock);
      refresh = 1'b0; clear = 1'b0; wr_en = 1'b0;
      chk("busy_after_refresh", busy, 1);
      chk("valid_not_yet", send_data_valid, 0);
      @(negedge clock);
      chk("valid_latency", send_data_valid, 1);
    end
    for (int i = 0; i < 64; i++) begin
      cnt = 0;
      while (!send_data_valid && cnt < 50) begin
        @(negedge clock);
        cnt++;
      end
      if (!send_data_valid) begin
        chk("valid_timeout", 0, 1);
        return;
      end
      chk($sformatf("char[%0d]", i), send_data, exp_buf[i]);
      if (mode == 1 && i == 10) begin
        write_cell(6'd10, 7'h41);
        write_cell(6'd11, 7'h42);
        chk("inflight_stable", send_data, exp_buf[10]);
        exp_buf[10] = 7'h41;
        exp_buf[11] = 7'h42;
      end
      if (mode == 3 && i == 30) begin
        reset = 1'b1;
        #1;
        chk("reset_valid_async", send_data_valid, 0);
        chk("reset_busy_async", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        send_done = 1'b0;
        for (int k = 0; k < 64; k++) exp_buf[k] = 7'h20;
        @(negedge clock);
        return;
      end
      send_done = 1'b1;
      if (mode == 2 && i == 5) refresh = 1'b1;
      repeat (hold) begin
        @(negedge clock);
        refresh = 1'b0;
      end
      send_done = 1'b0;
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    chk("frame_done_count", fd_cnt - fd0, 1);
`ifdef OLED_FEEDER_AUTO_REFRESH_EN
    chk("busy_stays", busy, 1);
`else
    chk("busy_end", busy, 0);
    repeat (5) @(negedge clock);
    chk("no_restart", send_data_valid, 0);
`endif
  endtask

  initial begin
    vecs[0] = '{6'd0,  7'h48, 7'h48};
    vecs[1] = '{6'd1,  7'h45, 7'h45};
    vecs[2] = '{6'd2,  7'h4C, 7'h4C};
    vecs[3] = '{6'd3,  7'h4C, 7'h4C};
    vecs[4] = '{6'd4,  7'h4F, 7'h4F};
    vecs[5] = '{6'd63, 7'h5A, 7'h5A};
    for (int k = 0; k < 64; k++) exp_buf[k] = 7'h20;

    @(negedge clock);
    chk("rst_valid", send_data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_data", send_data, 0);
    reset = 1'b0;
    @(negedge clock);

    // blank frame straight out of reset
    run_frame(1, 1'b1, 0, 1'b0, 1'b0, 6'd0, 7'h00);

`ifdef OLED_FEEDER_AUTO_REFRESH_EN
    // second frame follows without another refresh
    run_frame(1, 1'b0, 0, 1'b0, 1'b0, 6'd0, 7'h00);
    chk("auto_total_frames", fd_cnt, 2);
`else
    for (int v = 0; v < 6; v++) begin
      write_cell(vecs[v].addr, vecs[v].ch);
      exp_buf[vecs[v].addr] = vecs[v].exp;
    end
    run_frame(1, 1'b1, 0, 1'b0, 1'b0, 6'd0, 7'h00);
    run_frame(20, 1'b1, 0, 1'b0, 1'b0, 6'd0, 7'h00);
    run_frame(2, 1'b1, 2, 1'b0, 1'b0, 6'd0, 7'h00);
    run_frame(1, 1'b1, 1, 1'b0, 1'b0, 6'd0, 7'h00);
    run_frame(3, 1'b1, 0, 1'b0, 1'b0, 6'd0, 7'h00);
    run_frame(1, 1'b1, 3, 1'b0, 1'b0, 6'd0, 7'h00);
    run_frame(1, 1'b1, 0, 1'b0, 1'b0, 6'd0, 7'h00);

    // clear + write + refresh in one cycle: grid blanked, cell 3 = 'Q'
    write_cell(6'd0, 7'h41);
    for (int k = 0; k < 64; k++) exp_buf[k] = 7'h20;
    exp_buf[3] = 7'h51;
    run_frame(1, 1'b1, 0, 1'b1, 1'b1, 6'd3, 7'h51);

    // send_done already high when the frame starts: nothing advances until it toggles
    send_done = 1'b1;
    repeat (2) @(negedge clock);
    refresh = 1'b1;
    @(negedge clock);
    refresh = 1'b0;
    repeat (6) @(negedge clock);
    chk("held_done_cell0", send_data, exp_buf[0]);
    chk("held_done_busy", busy, 1);
    send_done = 1'b0;
    @(negedge clock);
    chk("held_done_still0", send_data, exp_buf[0]);
    run_frame(1, 1'b0, 0, 1'b0, 1'b0, 6'd0, 7'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
